// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module   : serial_add_ctrl_if
// Brief    : Request/response bundle for the bit-serial adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    modport master (
        output start, op_sub, a_in, b_in, cin_in,
        input  busy, done, sum_out, cout_out
    );

    modport slave (
        input  start, op_sub, a_in, b_in, cin_in,
        output busy, done, sum_out, cout_out
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl (+ fa)
// Brief    : Bit-serial add/subtract controller, one full-adder bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_add_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_res_next;

    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign w_res_next = w_fa_sum;
        end else begin : g_res_multi
            assign w_res_next = {w_fa_sum, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a_in;
                    // Subtract as a + ~b + 1; the +1 rides in on the initial carry.
                    b_sr_d   = bus.op_sub ? ~bus.b_in : bus.b_in;
                    carry_d  = bus.op_sub ? 1'b1 : bus.cin_in;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                res_sr_d = w_res_next;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = w_fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_BIT) begin
                    sum_d   = w_res_next;
                    cout_d  = w_fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy     = (state_q == S_ADD);
    assign bus.done     = (state_q == S_DONE);
    assign bus.sum_out  = sum_q;
    assign bus.cout_out = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_ctrl #(.WIDTH(1), .CNT_W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2**w, carry = bit w of the wide sum.
    function automatic logic [32:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
        logic [32:0] mask;
        logic [32:0] full;
        mask = (33'd1 << w) - 33'd1;
        if (sub)
            full = {1'b0, a} + (33'd1 << w) - {1'b0, b};
        else
            full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        return full & ((mask << 1) | 33'd1);
    endfunction

    // Call at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub, input bit junk);
        logic [32:0] exp;
        exp = ref_op(8, {24'd0, a}, {24'd0, b}, cin, sub);
        bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.cin_in = cin; bus8.op_sub = sub;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy8_add", {31'd0, bus8.busy}, 32'd1);
            check("done8_add", {31'd0, bus8.done}, 32'd0);
            bus8.start  = junk;
            bus8.a_in   = 8'($urandom);
            bus8.b_in   = 8'($urandom);
            bus8.cin_in = 1'($urandom);
            bus8.op_sub = 1'($urandom);
        end
        @(negedge clk);
        check("done8", {31'd0, bus8.done}, 32'd1);
        check("busy8_done", {31'd0, bus8.busy}, 32'd0);
        check("sum8", {24'd0, bus8.sum_out}, {24'd0, exp[7:0]});
        check("cout8", {31'd0, bus8.cout_out}, {31'd0, exp[8]});
        @(negedge clk);
        check("done8_idle", {31'd0, bus8.done}, 32'd0);
        check("busy8_idle", {31'd0, bus8.busy}, 32'd0);
    endtask

    task automatic run_op1(input logic a, input logic b, input logic cin);
        logic [32:0] exp;
        exp = ref_op(1, {31'd0, a}, {31'd0, b}, cin, 1'b0);
        bus1.start = 1'b1; bus1.a_in = a; bus1.b_in = b; bus1.cin_in = cin; bus1.op_sub = 1'b0;
        @(negedge clk);
        check("busy1_add", {31'd0, bus1.busy}, 32'd1);
        bus1.start = 1'b0;
        @(negedge clk);
        check("done1", {31'd0, bus1.done}, 32'd1);
        check("sum1", {31'd0, bus1.sum_out}, {31'd0, exp[0]});
        check("cout1", {31'd0, bus1.cout_out}, {31'd0, exp[1]});
        @(negedge clk);
        check("done1_idle", {31'd0, bus1.done}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.op_sub = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin_in = 1'b0;
        bus1.start = 1'b0; bus1.op_sub = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy8", {31'd0, bus8.busy}, 32'd0);
        check("rst_done8", {31'd0, bus8.done}, 32'd0);
        check("rst_sum8", {24'd0, bus8.sum_out}, 32'd0);
        check("rst_cout8", {31'd0, bus8.cout_out}, 32'd0);
        check("rst_done1", {31'd0, bus1.done}, 32'd0);
        @(negedge clk);

        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op8(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        // Start held high with scrambled operands through ADD/DONE, then back-to-back.
        run_op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        run_op8(8'h33, 8'h77, 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 16; n++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Abort mid-operation after three ADD edges.
        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        bus8.start = 1'b1; bus8.a_in = 8'h81; bus8.b_in = 8'h81; bus8.op_sub = 1'b0; bus8.cin_in = 1'b0;
        repeat (4) @(negedge clk);
        bus8.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy8", {31'd0, bus8.busy}, 32'd0);
        check("arst_done8", {31'd0, bus8.done}, 32'd0);
        check("arst_sum8", {24'd0, bus8.sum_out}, 32'd0);
        check("arst_cout8", {31'd0, bus8.cout_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_done8", {31'd0, bus8.done}, 32'd0);
            check("post_rst_sum8", {24'd0, bus8.sum_out}, 32'd0);
        end
        run_op8(8'hC3, 8'h3D, 1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 8; v++)
            run_op1(v[2], v[1], v[0]);

        bus8.start = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller built around one instance of the existing single-bit full adder `fa`.
- On a start request it captures two WIDTH-bit operands.
- It feeds them to `fa` LSB-first, one bit per clock, and stores the carry in a flip-flop between bits.
- It returns the registered WIDTH-bit result and carry-out with a done pulse.
- Used in the lab datapath where area is traded for latency.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32).
CNT_W, 5, width of the internal bit counter; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to begin an operation; sampled only in IDLE.
op_sub  input  1  0 = a_in + b_in + cin_in; 1 = a_in - b_in, implemented as a_in + ~b_in + 1 (cin_in ignored).
a_in  input  WIDTH  operand A, captured on the accepting edge.
b_in  input  WIDTH  operand B, captured on the accepting edge.
cin_in  input  1  carry-in for add; captured on the accepting edge.
busy  output  1  high while bits are being processed (state ADD).
done  output  1  one-cycle pulse when sum_out/cout_out are freshly valid.
sum_out  output  WIDTH  registered result; holds its value until the next completion.
cout_out  output  1  registered final carry. For subtract, 1 = no borrow.

Behaviour:
Reset:
- clk and an asynchronous active-low reset rst_n; reset asserts immediately and releases synchronously to the next clk edge.
- rst_n low forces: state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, counter=0, carry FF=0, shift registers=0.
- Reset mid-operation aborts it. No done pulse follows, and sum_out stays 0 until a new operation completes.

States: IDLE, ADD, DONE.

IDLE:
- start=1 at an edge triggers:
  - a_sr <= a_in;
  - b_sr <= op_sub ? ~b_in : b_in;
  - carry <= op_sub ? 1 : cin_in;
  - counter <= 0; res_sr <= 0; state <= ADD.
- start=0 keeps the state in IDLE.

ADD:
- `fa` inputs are a_sr[0], b_sr[0], carry (purely combinational).
- Each edge:
  - res_sr <= {fa.sum, res_sr[WIDTH-1:1]};
  - a_sr and b_sr shift right by 1;
  - carry <= fa.cout;
  - counter <= counter+1.
- When counter==WIDTH-1 at the edge: sum_out <= {fa.sum, res_sr[WIDTH-1:1]}, cout_out <= fa.cout, state <= DONE.

DONE:
- done=1 for exactly this one cycle.
- Next edge: state <= IDLE.
- start in DONE is ignored (not queued).

Timing and handshake:
- busy = (state==ADD). done = (state==DONE). Both are decoded from registered state only.
- Latency: start accepted at edge k → ADD covers edges k+1..k+WIDTH → done high in the cycle after edge k+WIDTH.
- Back-to-back throughput: one operation per WIDTH+2 cycles (accept edge + WIDTH ADD edges + DONE cycle).
- start while busy or done is ignored. Operand inputs may change freely after the accepting edge.
- Arithmetic is modulo 2**WIDTH; overflow is visible only through cout_out.
- WIDTH=1: a single ADD cycle, so done is high in the cycle after edge k+1.

Test Plan:
- WIDTH=8, add: a=0x5A, b=0x3C, cin=0, start at edge k → done high exactly after edge k+8; sum_out=0x96, cout_out=0; busy high for 8 cycles.
- Add wrap: a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout_out=1. Then a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout_out=1.
- Subtract: op_sub=1, a=0x10, b=0x01 → sum_out=0x0F, cout_out=1. Then a=0x01, b=0x02 → sum_out=0xFF, cout_out=0 (borrow).
- Busy protection: start=1 held with changing operands during ADD and DONE → only the first captured operation executes. The next operation starts at the first IDLE edge with start=1 (exactly WIDTH+2 edges after the first accept).
- Reset mid-op: assert rst_n=0 after 3 ADD cycles → busy, done, sum_out and cout_out go 0 immediately, without waiting for a clk edge. After release, no done pulse occurs unless start is given.
- WIDTH=1 instance: drive all 8 combinations of (a,b,cin) → sum_out/cout_out match the full-adder truth table; done high in the cycle after edge k+1.
